// File: rtl/sync_pkg.sv
// Shared definitions for the sync_arbiter family: FSM encoding, width helper and default widths.
// SYNC_ARB_PRIORITY0_EN (see sync_arbiter.sv) is the only build option; nothing here depends on it.
package sync_pkg;

  typedef enum logic {
    SYNC_IDLE   = 1'b0,
    SYNC_STROBE = 1'b1
  } sync_state_t;

  // Minimum of 1 so single-value counters and indices still get a real bit.
  function automatic int sync_clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEFAULT_CHANNELS = 4;
  localparam int CH_W             = sync_clog2(DEFAULT_CHANNELS);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req at or after ptr, wrapping past CHANNELS-1.
// valid is low when req is all zero; idx is then 0.
module rr_pick
  import sync_pkg::*;
#(
  parameter int CHANNELS = 4
) (
  input  logic [CHANNELS-1:0]             req,
  input  logic [sync_clog2(CHANNELS)-1:0] ptr,
  output logic [sync_clog2(CHANNELS)-1:0] idx,
  output logic                            valid
);

  localparam int IDX_W = sync_clog2(CHANNELS);

  logic [IDX_W-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cand = IDX_W'((int'(ptr) + i) % CHANNELS);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/sync_arbiter.sv
// N-channel slot arbiter: round-robin grant onto enabled slots, STROBE_CYCLES of strobe, then level done.
// Build option SYNC_ARB_PRIORITY0_EN: channel 0 wins every grant it is eligible for and never moves rr_ptr.
module sync_arbiter
  import sync_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STROBE_CYCLES = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enabled,
  input  logic [CHANNELS-1:0]             pending,
  output logic [CHANNELS-1:0]             strobe,
  output logic [CHANNELS-1:0]             done,
  output logic                            busy,
  output logic [sync_clog2(CHANNELS)-1:0] grant_id
);

  localparam int IDX_W = (CHANNELS == DEFAULT_CHANNELS) ? CH_W : sync_clog2(CHANNELS);
  localparam int CNT_W = sync_clog2(STROBE_CYCLES);

  sync_state_t      state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [IDX_W-1:0] grant_nxt;
  logic [IDX_W-1:0] rr_ptr, rr_nxt;
  logic [IDX_W-1:0] pick_idx, sel_idx;
  logic             pick_valid;
  logic             grant_pending;
  logic [CHANNELS-1:0] done_q, done_nxt;
  logic [CHANNELS-1:0] eligible;

  // Pointer after a grant ends; a priority-0 grant leaves the rotation among 1..N-1 untouched.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx,
                                                input logic [IDX_W-1:0] cur);
`ifdef SYNC_ARB_PRIORITY0_EN
    if (idx == '0) return cur;
`endif
    if (int'(idx) == CHANNELS - 1) return '0;
    return idx + IDX_W'(1);
  endfunction

  assign eligible      = pending & ~done_q;
  assign grant_pending = pending[grant_id];

  rr_pick #(
    .CHANNELS(CHANNELS)
  ) u_pick (
    .req  (eligible),
    .ptr  (rr_ptr),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  always_comb begin
    sel_idx = pick_idx;
`ifdef SYNC_ARB_PRIORITY0_EN
    if (eligible[0]) sel_idx = '0;
`endif
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    grant_nxt = grant_id;
    rr_nxt    = rr_ptr;
    // done_q drops for any channel that has released its request
    done_nxt  = done_q & pending;
    case (state)
      SYNC_IDLE: begin
        if (enabled && pick_valid) begin
          grant_nxt = sel_idx;
          count_nxt = CNT_W'(STROBE_CYCLES - 1);
          state_nxt = SYNC_STROBE;
        end
      end
      SYNC_STROBE: begin
        if (!grant_pending) begin
          state_nxt = SYNC_IDLE;
          rr_nxt    = next_ptr(grant_id, rr_ptr);
        end else if (count == '0) begin
          done_nxt[grant_id] = 1'b1;
          state_nxt          = SYNC_IDLE;
          rr_nxt             = next_ptr(grant_id, rr_ptr);
        end else begin
          count_nxt = count - CNT_W'(1);
        end
      end
      default: state_nxt = SYNC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SYNC_IDLE;
      count    <= '0;
      grant_id <= '0;
      rr_ptr   <= '0;
      done_q   <= '0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      grant_id <= grant_nxt;
      rr_ptr   <= rr_nxt;
      done_q   <= done_nxt;
    end
  end

  // Strobe is gated live by enabled and the requester's own pending level.
  always_comb begin
    strobe = '0;
    if (state == SYNC_STROBE && enabled && grant_pending) strobe[grant_id] = 1'b1;
  end

  assign done = done_q & pending;
  assign busy = (state == SYNC_STROBE);

  a_strobe_onehot0 : assert property (@(posedge clk) $onehot0(strobe));

endmodule

// File: tb/tb_sync_arbiter.sv
// Bench for sync_arbiter: two instances (STROBE_CYCLES 1 and 3) on shared inputs, checked against a slot-level model.
// Directed scenarios first, then randomized request traffic with occasional reset.
module tb_sync_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         enabled;
  logic [N-1:0] pending;
  logic [N-1:0] strobe_a, done_a, strobe_b, done_b;
  logic         busy_a, busy_b;
  logic [1:0]   gid_a, gid_b;

  always #5 clk = ~clk;

  sync_arbiter #(.CHANNELS(N), .STROBE_CYCLES(1)) u_dut_a (
    .clk(clk), .reset(reset), .enabled(enabled), .pending(pending),
    .strobe(strobe_a), .done(done_a), .busy(busy_a), .grant_id(gid_a)
  );

  sync_arbiter #(.CHANNELS(N), .STROBE_CYCLES(3)) u_dut_b (
    .clk(clk), .reset(reset), .enabled(enabled), .pending(pending),
    .strobe(strobe_b), .done(done_b), .busy(busy_b), .grant_id(gid_b)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference: per instance, is a slot in progress, for whom, how many strobe clocks remain,
  // which channels have completed, and where the round-robin search starts.
  int           m_len [2] = '{1, 3};
  bit           m_busy[2];
  int           m_gid [2];
  int           m_left[2];
  bit [N-1:0]   m_done[2];
  int           m_ptr [2];

  function automatic int pick(input int k, input bit [N-1:0] elig);
`ifdef SYNC_ARB_PRIORITY0_EN
    if (elig[0]) return 0;
`endif
    for (int i = 0; i < N; i++)
      if (elig[(m_ptr[k] + i) % N]) return (m_ptr[k] + i) % N;
    return -1;
  endfunction

  function automatic void release_slot(input int k, input int g);
    m_busy[k] = 1'b0;
`ifdef SYNC_ARB_PRIORITY0_EN
    if (g == 0) return;
`endif
    m_ptr[k] = (g + 1) % N;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] = 1'b0; m_gid[k] = 0; m_left[k] = 0; m_done[k] = '0; m_ptr[k] = 0;
      end else begin
        int g;
        int p;
        bit fin;
        bit [N-1:0] elig;
        g    = m_gid[k];
        fin  = 1'b0;
        elig = pending & ~m_done[k];
        if (!m_busy[k]) begin
          p = pick(k, elig);
          if (enabled && p >= 0) begin
            m_busy[k] = 1'b1; m_gid[k] = p; m_left[k] = m_len[k];
          end
        end else if (!pending[g]) begin
          release_slot(k, g);
        end else begin
          m_left[k]--;
          if (m_left[k] == 0) begin
            fin = 1'b1;
            release_slot(k, g);
          end
        end
        m_done[k] = m_done[k] & pending;
        if (fin) m_done[k][g] = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic [N-1:0] es [2];
    for (int k = 0; k < 2; k++) begin
      es[k] = '0;
      if (m_busy[k] && enabled && pending[m_gid[k]]) es[k][m_gid[k]] = 1'b1;
    end
    check("strobe_a", 32'(strobe_a), 32'(es[0]));
    check("done_a",   32'(done_a),   32'(m_done[0] & pending));
    check("busy_a",   32'(busy_a),   32'(m_busy[0]));
    check("grant_a",  32'(gid_a),    32'(m_gid[0]));
    check("strobe_b", 32'(strobe_b), 32'(es[1]));
    check("done_b",   32'(done_b),   32'(m_done[1] & pending));
    check("busy_b",   32'(busy_b),   32'(m_busy[1]));
    check("grant_b",  32'(gid_b),    32'(m_gid[1]));
  endtask

  // Inputs change just after posedge; outputs are compared at the following negedge.
  task automatic cycle(input bit r, input bit e, input logic [N-1:0] p);
    reset   = r;
    enabled = e;
    pending = p;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic repeat_cycle(input int n, input bit e, input logic [N-1:0] p);
    for (int i = 0; i < n; i++) cycle(1'b0, e, p);
  endtask

  initial begin
    logic [N-1:0] p;
    reset   = 1'b1;
    enabled = 1'b0;
    pending = '0;
    @(posedge clk);
    model_edge();
    #1;
    cycle(1'b1, 1'b0, 4'b0000);

    // Single request, slot opened mid-cycle, then closed while strobing.
    repeat_cycle(3, 1'b0, 4'b0001);
    repeat_cycle(2, 1'b1, 4'b0001);
    repeat_cycle(4, 1'b0, 4'b0001);
    repeat_cycle(2, 1'b0, 4'b0000);

    // All channels requesting with the slot always open.
    repeat_cycle(20, 1'b1, 4'b1111);
    repeat_cycle(2, 1'b1, 4'b0000);

    // Steer the pointer to 3, then a wrapping pair.
    repeat_cycle(6, 1'b1, 4'b0100);
    repeat_cycle(1, 1'b1, 4'b0000);
    repeat_cycle(12, 1'b1, 4'b1001);
    repeat_cycle(2, 1'b1, 4'b0000);

    // Abort mid-strobe.
    repeat_cycle(2, 1'b1, 4'b0010);
    repeat_cycle(3, 1'b1, 4'b0000);

    // Reset during strobe, request held across it.
    repeat_cycle(2, 1'b1, 4'b1000);
    cycle(1'b1, 1'b1, 4'b1000);
    repeat_cycle(2, 1'b0, 4'b1000);
    repeat_cycle(6, 1'b1, 4'b1000);
    repeat_cycle(2, 1'b1, 4'b0000);

    // Randomized requesters: mostly drop after done, occasionally abort early.
    for (int c = 0; c < 3000; c++) begin
      p = pending;
      for (int i = 0; i < N; i++) begin
        if (p[i]) begin
          if (m_done[0][i] || m_done[1][i]) begin
            if ($urandom_range(0, 1) == 0) p[i] = 1'b0;
          end else if ($urandom_range(0, 39) == 0) begin
            p[i] = 1'b0;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          p[i] = 1'b1;
        end
      end
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 7, p);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
